// File: rtl/seq_match_pkg.sv
// Shared definitions for the serial pattern-match controller: session state
// encodings and the width helper for the pattern-length field.
package seq_match_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/seq_match_window.sv
// Serial history window: shifts in accepted bits, tracks how many are valid and
// compares the most recent len-1 bits plus the live bit against the pattern.
module seq_match_window
    import seq_match_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               shift,
    input  logic               x,
    input  logic [MAX_LEN-1:0] pat,
    input  logic [LEN_W-1:0]   len,
    output logic               hit
);

    logic [MAX_LEN-2:0] window_reg;
    logic [LEN_W-1:0]   fill_reg;
    logic [LEN_W-1:0]   len_m1;
    logic [MAX_LEN-2:0] bit_ok;

    assign len_m1 = len - LEN_W'(1);

    // Window bit gi holds the bit that arrived gi+1 strobes ago; it must equal
    // pat[gi+1] only when it lies inside the active pattern length.
    for (genvar gi = 0; gi < MAX_LEN - 1; gi++) begin : g_cmp
        assign bit_ok[gi] = (LEN_W'(gi) >= len_m1) || (window_reg[gi] == pat[gi+1]);
    end

    assign hit = (fill_reg >= len_m1) && (&bit_ok) && (x == pat[0]);

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            window_reg <= '0;
            fill_reg   <= '0;
        end else if (shift) begin
            window_reg <= (MAX_LEN-1)'({window_reg, x});
            if (fill_reg < len)
                fill_reg <= fill_reg + LEN_W'(1);
        end
    end

endmodule

// File: rtl/seq_match_ctrl.sv
// Session controller for the run-time-configurable serial pattern detector:
// config handshake, start/abort sequencing, match counting and target stop.
module seq_match_ctrl
    import seq_match_pkg::*;
#(
    parameter  int MAX_LEN = 8,
    parameter  int CNT_W   = 8,
    localparam int LEN_W   = len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MAX_LEN-1:0] cfg_pat,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_ovl,
    input  logic [CNT_W-1:0]   cfg_target,
    input  logic               start,
    input  logic               abort,
    input  logic               x_valid,
    input  logic               x,
    output logic               z,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               busy,
    output logic               done
);

    state_t             state_reg;
    logic [MAX_LEN-1:0] pat_reg;
    logic [LEN_W-1:0]   len_reg;
    logic               ovl_reg;
    logic [CNT_W-1:0]   target_reg;
    logic [CNT_W-1:0]   cnt_reg;

    logic             cfg_fire;
    logic             run_active;
    logic             start_fire;
    logic             win_clr;
    logic             hit;
    logic             target_hit;
    logic [LEN_W-1:0] len_norm;

    // Abort also withdraws ready so a config offered in that cycle is not lost.
    assign cfg_ready  = (state_reg != RUN) && !abort;
    assign cfg_fire   = cfg_valid && cfg_ready;
    assign run_active = rst && !abort && (state_reg == RUN);
    assign start_fire = rst && !abort && !cfg_fire && start &&
                        ((state_reg == ARMED) || (state_reg == DONE));
    assign z          = run_active && x_valid && hit;
    assign win_clr    = start_fire || (z && !ovl_reg);
    assign len_norm   = ((cfg_len == '0) || (cfg_len > LEN_W'(MAX_LEN))) ? LEN_W'(MAX_LEN) : cfg_len;
    assign target_hit = (target_reg != '0) &&
                        (({1'b0, cnt_reg} + (CNT_W+1)'(1)) == {1'b0, target_reg});

    assign match_cnt = cnt_reg;
    assign busy      = (state_reg == RUN);
    assign done      = (state_reg == DONE);

    seq_match_window #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_window (
        .clk   (clk),
        .rst   (rst),
        .clr   (win_clr),
        .shift (run_active && x_valid),
        .x     (x),
        .pat   (pat_reg),
        .len   (len_reg),
        .hit   (hit)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg  <= IDLE;
            pat_reg    <= '0;
            len_reg    <= '0;
            ovl_reg    <= 1'b0;
            target_reg <= '0;
            cnt_reg    <= '0;
        end else if (abort) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else if (cfg_fire) begin
            pat_reg    <= cfg_pat;
            len_reg    <= len_norm;
            ovl_reg    <= cfg_ovl;
            target_reg <= cfg_target;
            cnt_reg    <= '0;
            state_reg  <= ARMED;
        end else begin
            case (state_reg)
                ARMED, DONE: begin
                    if (start) begin
                        cnt_reg   <= '0;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    if (z) begin
                        if (!(&cnt_reg))
                            cnt_reg <= cnt_reg + CNT_W'(1);
                        if (target_hit)
                            state_reg <= DONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_match_ctrl.sv
// Self-checking bench for seq_match_ctrl: directed session scenarios plus randomized
// sessions, checked against a queue-based model of the detection rules.
module tb_seq_match_ctrl;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 8;
    localparam int LEN_W   = 4;
    localparam int CNT_MAX = 255;
    localparam int M_IDLE = 0, M_ARMED = 1, M_RUN = 2, M_DONE = 3;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               cfg_valid = 1'b0;
    logic               cfg_ready;
    logic [MAX_LEN-1:0] cfg_pat = '0;
    logic [LEN_W-1:0]   cfg_len = '0;
    logic               cfg_ovl = 1'b0;
    logic [CNT_W-1:0]   cfg_target = '0;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic               x_valid = 1'b0;
    logic               x = 1'b0;
    logic               z;
    logic [CNT_W-1:0]   match_cnt;
    logic               busy;
    logic               done;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: session phase, latched config, counter and bit history.
    int           m_state = M_IDLE;
    bit [7:0]     m_pat = '0;
    int           m_len = 0;
    bit           m_ovl = 1'b0;
    int           m_target = 0;
    int           m_cnt = 0;
    bit           hist[$];

    always #5 clk = ~clk;

    seq_match_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_pat    (cfg_pat),
        .cfg_len    (cfg_len),
        .cfg_ovl    (cfg_ovl),
        .cfg_target (cfg_target),
        .start      (start),
        .abort      (abort),
        .x_valid    (x_valid),
        .x          (x),
        .z          (z),
        .match_cnt  (match_cnt),
        .busy       (busy),
        .done       (done)
    );

    // True when the last m_len bits seen (including xb) spell the pattern MSB-first.
    function automatic bit model_match(input bit xb);
        bit h[$];
        h = hist;
        h.push_back(xb);
        if (m_len == 0 || h.size() < m_len) return 1'b0;
        for (int i = 0; i < m_len; i++)
            if (h[h.size() - m_len + i] != m_pat[m_len-1-i]) return 1'b0;
        return 1'b1;
    endfunction

    // One clock: drive inputs, sample combinational outputs at negedge, advance model.
    task automatic cyc(input bit cv, input bit st, input bit ab, input bit xv, input bit xb,
                       output bit z_o, output bit z_e, output bit rdy_o, output bit rdy_e);
        cfg_valid = cv; start = st; abort = ab; x_valid = xv; x = xb;
        @(negedge clk);
        z_e   = rst && !ab && (m_state == M_RUN) && xv && model_match(xb);
        rdy_e = !ab && (m_state != M_RUN);
        z_o   = z;
        rdy_o = cfg_ready;
        @(posedge clk);
        if (!rst) begin
            m_state = M_IDLE; m_pat = '0; m_len = 0; m_ovl = 0; m_target = 0; m_cnt = 0;
            hist.delete();
        end else if (ab) begin
            m_state = M_IDLE; m_cnt = 0;
        end else if (cv && m_state != M_RUN) begin
            m_pat = cfg_pat;
            m_len = (cfg_len == 0 || cfg_len > MAX_LEN) ? MAX_LEN : int'(cfg_len);
            m_ovl = cfg_ovl; m_target = cfg_target; m_cnt = 0; m_state = M_ARMED;
        end else if ((m_state == M_ARMED || m_state == M_DONE) && st) begin
            hist.delete(); m_cnt = 0; m_state = M_RUN;
        end else if (m_state == M_RUN && xv) begin
            hist.push_back(xb);
            if (hist.size() > MAX_LEN) void'(hist.pop_front());
            if (z_e) begin
                if (m_target != 0 && m_cnt + 1 == m_target) m_state = M_DONE;
                if (m_cnt < CNT_MAX) m_cnt++;
                if (!m_ovl) hist.delete();
            end
        end
        #1;
        cfg_valid = 1'b0; start = 1'b0; abort = 1'b0; x_valid = 1'b0;
    endtask

    task automatic do_cfg(input bit [7:0] p, input int l, input bit o, input int t);
        bit a, b, c, d;
        cyc(0, 0, 1, 0, 0, a, b, c, d);
        cfg_pat = p; cfg_len = LEN_W'(l); cfg_ovl = o; cfg_target = CNT_W'(t);
        cyc(1, 0, 0, 0, 0, a, b, c, d);
    endtask

    task automatic do_start();
        bit a, b, c, d;
        cyc(0, 1, 0, 0, 0, a, b, c, d);
    endtask

    task automatic test_reset();
        bit zo, ze, ro, re;
        rst = 1'b0;
        cyc(0, 0, 0, 1, 1, zo, ze, ro, re);
        rst = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b expected 0", done); end
        n_checks++; if (match_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", match_cnt); end
        n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b expected 1", cfg_ready); end
        n_checks++; if (z !== 1'b0) begin n_fail++; $display("FAIL reset_z: got %0b expected 0", z); end
        $display("test_reset: outputs checked after reset");
    endtask

    task automatic run_stream(input string name, input logic [11:0] s, input int n, input logic [11:0] zmask_exp);
        bit zo, ze, ro, re;
        logic [11:0] zmask = '0;
        for (int i = 0; i < n; i++) begin
            cyc(0, 0, 0, 1, s[n-1-i], zo, ze, ro, re);
            zmask[i] = zo;
            n_checks++; if (zo !== ze) begin n_fail++; $display("FAIL %s_z_bit%0d: got %0b expected %0b", name, i + 1, zo, ze); end
            n_checks++; if (match_cnt !== CNT_W'(m_cnt)) begin n_fail++; $display("FAIL %s_cnt_bit%0d: got %0d expected %0d", name, i + 1, match_cnt, m_cnt); end
        end
        n_checks++; if (zmask !== zmask_exp) begin n_fail++; $display("FAIL %s_zmask: got %b expected %b", name, zmask, zmask_exp); end
        $display("%s: %0d bits, z mask %b, cnt %0d", name, n, zmask, match_cnt);
    endtask

    task automatic test_overlap();
        do_cfg(8'b0010_1010, 6, 1, 0); do_start();
        run_stream("overlap", 12'b1010_1010_1010, 12, 12'b1010_1010_0000);
        n_checks++; if (match_cnt !== 8'd4) begin n_fail++; $display("FAIL overlap_cnt: got %0d expected 4", match_cnt); end
    endtask

    task automatic test_nonoverlap();
        do_cfg(8'b0010_1010, 6, 0, 0); do_start();
        run_stream("nonoverlap", 12'b1010_1010_1010, 12, 12'b1000_0010_0000);
        n_checks++; if (match_cnt !== 8'd2) begin n_fail++; $display("FAIL nonoverlap_cnt: got %0d expected 2", match_cnt); end
    endtask

    task automatic test_target();
        do_cfg(8'b0000_0110, 3, 1, 2); do_start();
        run_stream("target", 12'b0000_0011_0110, 6, 12'b0000_0010_0100);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL target_done: got %0b expected 1", done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL target_busy: got %0b expected 0", busy); end
        run_stream("target_after", 12'b0000_0000_0110, 3, 12'b0);
        n_checks++; if (match_cnt !== 8'd2) begin n_fail++; $display("FAIL target_hold_cnt: got %0d expected 2", match_cnt); end
        do_start();
        n_checks++; if (match_cnt !== 8'd0 || busy !== 1'b1) begin n_fail++; $display("FAIL target_restart: got cnt %0d busy %0b expected cnt 0 busy 1", match_cnt, busy); end
    endtask

    task automatic test_gaps_handshake();
        bit zo, ze, ro, re;
        do_cfg(8'b0000_1011, 4, 1, 0); do_start();
        run_stream("gap_head", 12'b10, 2, 12'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 1'($urandom), zo, ze, ro, re);
            n_checks++; if (zo !== 1'b0) begin n_fail++; $display("FAIL gap_idle_z%0d: got %0b expected 0", i, zo); end
        end
        run_stream("gap_tail", 12'b11, 2, 12'b10);
        n_checks++; if (match_cnt !== 8'd1) begin n_fail++; $display("FAIL gap_cnt: got %0d expected 1", match_cnt); end
        cfg_pat = 8'b0000_0001; cfg_len = 4'd2; cfg_ovl = 1'b1; cfg_target = 8'd0;
        for (int i = 0; i < 2; i++) begin
            cyc(1, 0, 0, 0, 0, zo, ze, ro, re);
            n_checks++; if (ro !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL run_holdoff%0d: got ready %0b busy %0b expected ready 0 busy 1", i, ro, busy); end
        end
        cyc(1, 0, 1, 0, 0, zo, ze, ro, re);
        cyc(1, 0, 0, 0, 0, zo, ze, ro, re);
        n_checks++; if (ro !== 1'b1) begin n_fail++; $display("FAIL idle_ready: got %0b expected 1", ro); end
        do_start();
        run_stream("new_cfg", 12'b0101, 4, 12'b1010);
        $display("test_gaps_handshake: held-off config accepted after abort");
    endtask

    task automatic test_abort_reset();
        bit zo, ze, ro, re;
        do_cfg(8'b0000_0101, 3, 1, 0); do_start();
        run_stream("abort_head", 12'b10, 2, 12'b0);
        cyc(0, 0, 1, 1, 1, zo, ze, ro, re);
        n_checks++; if (zo !== 1'b0) begin n_fail++; $display("FAIL abort_z: got %0b expected 0", zo); end
        n_checks++; if (busy !== 1'b0 || match_cnt !== 8'd0) begin n_fail++; $display("FAIL abort_state: got busy %0b cnt %0d expected 0 0", busy, match_cnt); end
        do_start();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_start: got busy %0b expected 0", busy); end
        do_cfg(8'b0000_0101, 3, 1, 0); do_start();
        run_stream("rst_head", 12'b10110, 5, 12'b00100);
        rst = 1'b0;
        cyc(0, 0, 0, 1, 1, zo, ze, ro, re);
        n_checks++; if (zo !== 1'b0) begin n_fail++; $display("FAIL rst_z: got %0b expected 0", zo); end
        rst = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0 || match_cnt !== 8'd0 || cfg_ready !== 1'b1)
            begin n_fail++; $display("FAIL rst_outputs: got busy %0b done %0b cnt %0d ready %0b expected 0 0 0 1", busy, done, match_cnt, cfg_ready); end
        do_start();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_cfg_cleared: got busy %0b expected 0", busy); end
    endtask

    task automatic test_edge();
        bit zo, ze, ro, re;
        do_cfg(8'b0000_0001, 1, 1, 0); do_start();
        run_stream("len1", 12'b111, 3, 12'b111);
        for (int i = 0; i < 257; i++) begin
            cyc(0, 0, 0, 1, 1, zo, ze, ro, re);
            n_checks++; if (zo !== 1'b1 || zo !== ze) begin n_fail++; $display("FAIL sat_z%0d: got %0b expected 1", i, zo); end
        end
        n_checks++; if (match_cnt !== 8'd255 || busy !== 1'b1) begin n_fail++; $display("FAIL sat_cnt: got %0d busy %0b expected 255 1", match_cnt, busy); end
        do_cfg(8'hA5, 0, 1, 0); do_start();
        run_stream("len0", 12'h0A5, 8, 12'h080);
        do_cfg(8'h3C, 12, 1, 0); do_start();
        run_stream("len12", 12'h03C, 8, 12'h080);
    endtask

    task automatic test_random();
        bit zo, ze, ro, re, cv, st, ab, xv, xb;
        bit [7:0] pat;
        int lenr, eff, p, fails0;
        fails0 = n_fail;
        for (int s = 0; s < 20; s++) begin
            pat = 8'($urandom); lenr = $urandom_range(0, 15);
            do_cfg(pat, lenr, 1'($urandom), $urandom_range(0, 4)); do_start();
            eff = (lenr == 0 || lenr > MAX_LEN) ? MAX_LEN : lenr;
            p = 0;
            for (int c = 0; c < 60; c++) begin
                cv = ($urandom % 16) == 0; st = ($urandom % 8) == 0;
                ab = ($urandom % 64) == 0; xv = ($urandom % 4) != 0;
                xb = pat[eff-1-p];
                if ($urandom % 8 == 0) xb = ~xb;
                if (xv) p = (p + 1) % eff;
                cyc(cv, st, ab, xv, xb, zo, ze, ro, re);
                n_checks++; if (zo !== ze) begin n_fail++; $display("FAIL rnd_z s%0d c%0d: got %0b expected %0b", s, c, zo, ze); end
                n_checks++; if (ro !== re) begin n_fail++; $display("FAIL rnd_ready s%0d c%0d: got %0b expected %0b", s, c, ro, re); end
                n_checks++; if (match_cnt !== CNT_W'(m_cnt)) begin n_fail++; $display("FAIL rnd_cnt s%0d c%0d: got %0d expected %0d", s, c, match_cnt, m_cnt); end
                n_checks++; if (busy !== (m_state == M_RUN) || done !== (m_state == M_DONE))
                    begin n_fail++; $display("FAIL rnd_state s%0d c%0d: got busy %0b done %0b expected model state %0d", s, c, busy, done, m_state); end
            end
            $display("random session %0d: pat %b len %0d cnt %0d", s, pat, eff, match_cnt);
        end
        $display("test_random: %0d new failures", n_fail - fails0);
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_nonoverlap();
        test_target();
        test_gaps_handshake();
        test_abort_reset();
        test_edge();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
